// File: rtl/shift_engine.sv
// Configurable shift register with parallel load, single-step shifts and
// automatic WIDTH-bit transfers sequenced by a small IDLE/SHIFT/DONE FSM.
module shift_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enable,
  input  logic             start,
  input  logic             direction,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out_data,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_done_nxt;
  logic             w_eff_dir;

  // One shift step; mode 11 (and arithmetic-left == logical-left) handled here.
  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0] v,
    input logic             dir,
    input logic [1:0]       md,
    input logic             sin
  );
    logic [WIDTH-1:0] res;
    res = v;
    if (!dir) begin
      case (md)
        2'b00, 2'b10: res = {v[WIDTH-2:0], sin};
        2'b01:        res = {v[WIDTH-2:0], v[WIDTH-1]};
        default:      res = v;
      endcase
    end else begin
      case (md)
        2'b00:   res = {sin, v[WIDTH-1:1]};
        2'b01:   res = {v[0], v[WIDTH-1:1]};
        2'b10:   res = {v[WIDTH-1], v[WIDTH-1:1]};
        default: res = v;
      endcase
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_mode   <= 2'b00;
      out_data <= '0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir    <= w_dir_nxt;
      r_mode   <= w_mode_nxt;
      out_data <= w_data_nxt;
      done     <= w_done_nxt;
    end
  end

  // Next-state logic; in IDLE requests are prioritised load > start > enable.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_mode_nxt  = r_mode;
    w_data_nxt  = out_data;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_data_nxt = load_data;
        end else if (start) begin
          w_dir_nxt   = direction;
          w_mode_nxt  = mode;
          w_cnt_nxt   = CNT_W'(WIDTH);
          w_state_nxt = SHIFT;
        end else if (enable) begin
          w_data_nxt = f_shift(out_data, direction, mode, ser_in);
        end
      end
      SHIFT: begin
        w_data_nxt = f_shift(out_data, r_dir, r_mode, ser_in);
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_eff_dir = (r_state == IDLE) ? direction : r_dir;
  assign ser_out   = w_eff_dir ? out_data[0] : out_data[WIDTH-1];
  assign busy      = (r_state == SHIFT);

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits; legal range 2..64.
REQ-002 SHALL have derived localparam CNT_W = $clog2(WIDTH+1): bit-count width.
REQ-003 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port load, input, 1: parallel load request.
REQ-006 SHALL have port load_data, input, WIDTH: parallel load value.
REQ-007 SHALL have port enable, input, 1: single-step shift request.
REQ-008 SHALL have port start, input, 1: automatic WIDTH-bit transfer request.
REQ-009 SHALL have port direction, input, 1: 0 = left (toward MSB), 1 = right (toward LSB).
REQ-010 SHALL have port mode, input, 2: 00 logical, 01 rotate, 10 arithmetic, 11 hold.
REQ-011 SHALL have port ser_in, input, 1: serial data in.
REQ-012 SHALL have port out_data, output reg, WIDTH: register contents.
REQ-013 SHALL have port ser_out, output, 1: serial data out.
REQ-014 SHALL have port busy, output, 1: high while a transfer is in progress.
REQ-015 SHALL have port done, output reg, 1: one-cycle pulse at transfer completion.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 SHALL transition IDLE->SHIFT on start; SHIFT->DONE when the last bit is shifted; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL, in IDLE, apply priority load > start > enable; lower-priority requests in the same cycle are dropped.
REQ-019 SHALL, on load in IDLE, set out_data = load_data in the next cycle with no shift.
REQ-020 SHALL, on start in IDLE, latch direction and mode into internal registers, set the bit counter to WIDTH, and perform no shift in that cycle.
REQ-021 SHALL, in SHIFT, perform one shift per cycle using the latched direction/mode, decrement the counter, and enter DONE when the counter reaches 1 before decrement; exactly WIDTH shifts per transfer.
REQ-022 SHALL, on enable in IDLE, perform one shift using the live direction/mode.
REQ-023 SHALL define one shift, left: logical {out[W-2:0], ser_in}; rotate {out[W-2:0], out[W-1]}; arithmetic same as logical.
REQ-024 SHALL define one shift, right: logical {ser_in, out[W-1:1]}; rotate {out[0], out[W-1:1]}; arithmetic {out[W-1], out[W-1:1]}.
REQ-025 SHALL treat mode 11 as hold: out_data unchanged, but the counter still decrements in SHIFT.
REQ-026 SHALL drive ser_out combinationally as out_data[W-1] when the effective direction is left, else out_data[0]; effective direction is the latched value in SHIFT/DONE and the live input in IDLE.
REQ-027 SHALL assert busy combinationally in SHIFT only; busy is low in IDLE and DONE.
REQ-028 SHALL register done high for exactly the DONE cycle.
REQ-029 SHALL ignore load, start and enable while in SHIFT or DONE; a start held high re-triggers only once back in IDLE.
REQ-030 SHALL hold out_data when no request is active in IDLE.

Reset
REQ-031 SHALL, on rstn low at any time including mid-transfer, immediately set out_data = 0, done = 0, counter = 0, latched direction/mode = 0, state = IDLE; busy and ser_out therefore read 0.
REQ-032 SHALL resume normal operation on the first rising clk edge after rstn deasserts, with no pending request carried over.

Verification
REQ-033 SHALL pass: WIDTH=8, load 0xA5, start, direction=0, mode=01 -> busy for 8 cycles, ser_out sequence 1,0,1,0,0,1,0,1, out_data back to 0xA5, done pulse 1 cycle.
REQ-034 SHALL pass: WIDTH=8, load 0x80, enable x3, direction=1, mode=10 -> out_data 0xC0, 0xE0, 0xF0.
REQ-035 SHALL pass: WIDTH=8, out_data 0x00, start, direction=0, mode=00, ser_in pattern 1,1,0,1,0,0,1,1 -> out_data 0xD3 at done.
REQ-036 SHALL pass: load, start, enable asserted together in IDLE -> only load takes effect, no busy.
REQ-037 SHALL pass: rstn pulsed low at shift 4 of a transfer -> out_data 0, busy 0, done never pulses; subsequent start runs a full 8 shifts.
REQ-038 SHALL pass: direction and mode toggled during SHIFT -> result identical to unchanged inputs; mode 11 transfer -> out_data unchanged, done after 8 cycles.
